instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the synchronous-read instruction ROM.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_skid_reg.sv | 33 +++
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_t;

    typedef logic [31:0] pc_t;

    localparam pc_t INSTR_BYTES = 32'd4;

    function automatic pc_t align_pc(input pc_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register that parks a returned ROM word and its PC while decode stalls.
module fetch_skid_reg
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  pc_t                   load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output pc_t                   pc
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of a synchronous-read instruction ROM: owns the PC, pairs
// returned words with their PCs and hands them to decode over valid/ready.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int  ADDR_WIDTH = 10,
    parameter int  DATA_WIDTH = 32,
    parameter pc_t RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_pc_plus4
);

    fetch_state_t          state;
    pc_t                   pc;
    pc_t                   pc_f1;
    logic                  valid_f1;

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_instr;
    pc_t                   skid_pc;
    logic                  skid_load;
    logic                  skid_clear;

    pc_t                   redirect_target;
    pc_t                   addr_src;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_instr;
    pc_t                   sel_pc;
    logic                  fire;
    logic                  unused_addr_bits;

    assign redirect_target = align_pc(redirect_pc);

    assign sel_valid = (state == STALL) ? skid_valid : valid_f1;
    assign sel_instr = (state == STALL) ? skid_instr : imem_data;
    assign sel_pc    = (state == STALL) ? skid_pc    : pc_f1;

    assign out_valid    = sel_valid;
    assign out_instr    = sel_valid ? sel_instr : '0;
    assign out_pc       = sel_valid ? sel_pc : '0;
    assign out_pc_plus4 = sel_valid ? sel_pc + INSTR_BYTES : '0;

    assign fire = out_valid & out_ready;

    // A stall parks the word currently on imem_data; the ROM then re-reads pc_f1 in STALL.
    assign skid_load  = !redirect_valid && (state == RUN) && valid_f1 && !out_ready;
    assign skid_clear = redirect_valid || ((state == STALL) && fire);

    // The redirect target bypasses the PC register so its word returns one cycle later.
    always_comb begin
        addr_src = pc;
        if (redirect_valid) begin
            addr_src = redirect_target;
        end else if (state == STALL) begin
            addr_src = pc_f1;
        end
    end

    assign imem_addr        = addr_src[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{addr_src[31:ADDR_WIDTH+2], addr_src[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            pc_f1    <= '0;
            valid_f1 <= 1'b0;
        end else if (redirect_valid) begin
            state    <= RUN;
            pc_f1    <= redirect_target;
            valid_f1 <= fetch_en;
            pc       <= fetch_en ? redirect_target + INSTR_BYTES : redirect_target;
        end else begin
            case (state)
                RUN: begin
                    pc_f1    <= pc;
                    valid_f1 <= fetch_en;
                    if (fetch_en) begin
                        pc <= pc + INSTR_BYTES;
                    end
                    if (valid_f1 && !out_ready) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (fire) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    fetch_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (imem_data),
        .load_pc    (pc_f1),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a cycle table for streaming, stall, redirect and
// drain behaviour, plus hand sequences for async reset and PC wrap.
module tb_instruction_fetch;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] einstr;
        logic [31:0] epc;
        logic [9:0]  eaddr;
    } vec_t;

    localparam int NUM_VECS = 26;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic        w_fetch_en;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic [9:0]  w_imem_addr;
    logic [31:0] w_imem_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_pc_plus4;

    int compared;
    int mismatched;
    vec_t vecs [NUM_VECS];

    instruction_fetch #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4)
    );

    instruction_fetch #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32),
        .RESET_PC  (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (w_fetch_en),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .imem_addr      (w_imem_addr),
        .imem_data      (w_imem_data),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc),
        .out_pc_plus4   (w_out_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word i holds i+1.
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {22'd0, a} + 32'd1;
    endfunction

    always @(posedge clk) imem_data   <= rom_word(imem_addr);
    always @(posedge clk) w_imem_data <= rom_word(w_imem_addr);

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [9:0] ea);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.einstr = ei; v.epc = ep; v.eaddr = ea;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        fetch_en       = v.fe;
        out_ready      = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [31:0] ei,
                               input logic [31:0] ep, input logic [9:0] ea);
        logic [31:0] ep4;
        ep4 = ev ? ep + 32'd4 : 32'd0;
        checkVal({tag, ".out_valid"},    {31'd0, out_valid}, {31'd0, ev});
        checkVal({tag, ".out_instr"},    out_instr,    ev ? ei : 32'd0);
        checkVal({tag, ".out_pc"},       out_pc,       ev ? ep : 32'd0);
        checkVal({tag, ".out_pc_plus4"}, out_pc_plus4, ep4);
        checkVal({tag, ".imem_addr"},    {22'd0, imem_addr}, {22'd0, ea});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;

        // fe, rdy, rv, rpc, exp valid, exp instr, exp pc, exp imem_addr
        vecs[0]  = mk(1, 1, 0, 32'h0,   0, 0,   32'h0,   10'd0);
        vecs[1]  = mk(1, 1, 0, 32'h0,   1, 1,   32'h0,   10'd1);
        vecs[2]  = mk(1, 1, 0, 32'h0,   1, 2,   32'h4,   10'd2);
        vecs[3]  = mk(1, 0, 0, 32'h0,   1, 3,   32'h8,   10'd3);
        vecs[4]  = mk(1, 0, 0, 32'h0,   1, 3,   32'h8,   10'd3);
        vecs[5]  = mk(1, 0, 0, 32'h0,   1, 3,   32'h8,   10'd3);
        vecs[6]  = mk(1, 1, 0, 32'h0,   1, 3,   32'h8,   10'd3);
        vecs[7]  = mk(1, 1, 0, 32'h0,   1, 4,   32'hC,   10'd4);
        vecs[8]  = mk(1, 0, 0, 32'h0,   1, 5,   32'h10,  10'd5);
        vecs[9]  = mk(1, 0, 1, 32'h42,  1, 5,   32'h10,  10'd16);
        vecs[10] = mk(1, 1, 0, 32'h0,   1, 17,  32'h40,  10'd17);
        vecs[11] = mk(1, 1, 1, 32'h100, 1, 18,  32'h44,  10'd64);
        vecs[12] = mk(1, 1, 0, 32'h0,   1, 65,  32'h100, 10'd65);
        vecs[13] = mk(0, 1, 0, 32'h0,   1, 66,  32'h104, 10'd66);
        vecs[14] = mk(0, 1, 0, 32'h0,   0, 0,   32'h0,   10'd66);
        vecs[15] = mk(1, 1, 0, 32'h0,   0, 0,   32'h0,   10'd66);
        vecs[16] = mk(1, 0, 0, 32'h0,   1, 67,  32'h108, 10'd67);
        vecs[17] = mk(0, 0, 0, 32'h0,   1, 67,  32'h108, 10'd67);
        vecs[18] = mk(0, 1, 0, 32'h0,   1, 67,  32'h108, 10'd67);
        vecs[19] = mk(0, 1, 0, 32'h0,   1, 68,  32'h10C, 10'd68);
        vecs[20] = mk(0, 1, 0, 32'h0,   0, 0,   32'h0,   10'd68);
        vecs[21] = mk(0, 1, 1, 32'h203, 0, 0,   32'h0,   10'd128);
        vecs[22] = mk(1, 1, 0, 32'h0,   0, 0,   32'h0,   10'd128);
        vecs[23] = mk(1, 1, 0, 32'h0,   1, 129, 32'h200, 10'd129);
        vecs[24] = mk(1, 0, 0, 32'h0,   1, 130, 32'h204, 10'd130);
        vecs[25] = mk(1, 0, 0, 32'h0,   1, 130, 32'h204, 10'd130);

        rst              = 1'b0;
        fetch_en         = 1'b1;
        out_ready        = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        w_fetch_en       = 1'b1;
        w_out_ready      = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 32'h0, 10'd0);
        checkVal("wrap_reset.imem_addr", {22'd0, w_imem_addr}, 32'd1023);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].einstr, vecs[i].epc, vecs[i].eaddr);
            @(negedge clk);
        end

        // Still stalled with the skid full: reset must clear the outputs without a clock edge.
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'h0, 32'h0, 10'd0);
        checkVal("wrap_async_reset.out_valid", {31'd0, w_out_valid}, 32'd0);
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        #1;
        checkOutput("restart0", 1'b0, 32'h0, 32'h0, 10'd0);
        checkVal("wrap0.out_valid", {31'd0, w_out_valid}, 32'd0);
        checkVal("wrap0.imem_addr", {22'd0, w_imem_addr}, 32'd1023);

        @(negedge clk);
        fetch_en = 1'b0;
        #1;
        checkOutput("restart1", 1'b1, 32'd1, 32'h0, 10'd1);
        checkVal("wrap1.out_valid",    {31'd0, w_out_valid}, 32'd1);
        checkVal("wrap1.out_pc",       w_out_pc,       32'hFFFF_FFFC);
        checkVal("wrap1.out_pc_plus4", w_out_pc_plus4, 32'h0);
        checkVal("wrap1.out_instr",    w_out_instr,    32'd1024);
        checkVal("wrap1.imem_addr",    {22'd0, w_imem_addr}, 32'd0);

        @(negedge clk);
        #1;
        checkOutput("restart2", 1'b0, 32'h0, 32'h0, 10'd1);
        checkVal("wrap2.out_pc",    w_out_pc,    32'h0);
        checkVal("wrap2.out_instr", w_out_instr, 32'd1);
        checkVal("wrap2.imem_addr", {22'd0, w_imem_addr}, 32'd1);

        @(negedge clk);
        #1;
        checkOutput("restart3", 1'b0, 32'h0, 32'h0, 10'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
